// File: rtl/sdr_dsp_pkg.sv
// Shared DSP definitions for the CIC compensation path: widths, saturation,
// FSM encoding and the default inverse-sinc^5 coefficient table.
package sdr_dsp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    localparam int MAX_TAPS = 64;
    localparam int TAB_AW   = $clog2(MAX_TAPS);

    typedef int coef_table_t [MAX_TAPS];

    // The centre pair differs by one LSB so the table sums to exactly 32767.
    localparam coef_table_t DEFAULT_COEF = '{
        0: 12,     1: -40,    2: 85,     3: -160,
        4: 290,    5: -560,   6: 1300,   7: 15457,
        8: 15456,  9: 1300,   10: -560,  11: 290,
        12: -160,  13: 85,    14: -40,   15: 12,
        default: 0
    };

    function automatic int acc_width(input int coef_w, input int taps);
        return 8 + coef_w + $clog2(taps);
    endfunction

    function automatic longint saturate(input longint v, input int out_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (out_w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// Sample/strobe bundle between the CIC decimator and the compensation FIR.
interface cic_comp_fir_if #(
    parameter int OUT_W = 16
);
    logic signed [7:0]       in_data;
    logic                    in_clk;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    overrun;

    modport master (
        output in_data, in_clk,
        input  out_data, out_valid, overrun
    );

    modport slave (
        input  in_data, in_clk,
        output out_data, out_valid, overrun
    );
endinterface

// File: rtl/cic_comp_coef_rom.sv
// Combinational coefficient lookup; the table is a parameter so it can be swapped.
module cic_comp_coef_rom
    import sdr_dsp_pkg::*;
#(
    parameter int          TAPS       = 16,
    parameter int          COEF_W     = 16,
    parameter coef_table_t COEF_TABLE = DEFAULT_COEF
) (
    input  logic [$clog2(TAPS)-1:0] k,
    output logic signed [COEF_W-1:0] coef
);

    always_comb begin
        coef = COEF_W'(COEF_TABLE[TAB_AW'(k)]);
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Time-shared single-MAC compensation FIR behind the CIC decimator, with
// optional extra decimation, rounding and output saturation.
module cic_comp_fir
    import sdr_dsp_pkg::*;
#(
    parameter int          TAPS       = 16,
    parameter int          DECIM      = 1,
    parameter int          COEF_W     = 16,
    parameter int          OUT_W      = 16,
    parameter int          OUT_SHIFT  = 7,
    parameter coef_table_t COEF_TABLE = DEFAULT_COEF
) (
    input  logic         clk,
    input  logic         rst_n,
    cic_comp_fir_if.slave bus
);

    localparam int     AW     = $clog2(TAPS);
    localparam int     PH_W   = 5;
    localparam int     PROD_W = 8 + COEF_W;
    localparam int     ACC_W  = acc_width(COEF_W, TAPS);
    localparam longint RND    = (longint'(1) <<< OUT_SHIFT) >>> 1;

    logic                    in_clk_q, in_clk_d;
    logic                    pending_q, pending_d;
    logic signed [7:0]       pend_data_q, pend_data_d;
    logic signed [7:0]       smp_q [TAPS];
    logic signed [7:0]       smp_d [TAPS];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [AW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]              state_q, state_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic                     edge_det;
    logic                     consume;
    logic [AW-1:0]            rd_idx;
    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;

    cic_comp_coef_rom #(
        .TAPS       (TAPS),
        .COEF_W     (COEF_W),
        .COEF_TABLE (COEF_TABLE)
    ) u_rom (
        .k    (k_q),
        .coef (coef)
    );

    always_comb begin
        in_clk_d    = bus.in_clk;
        edge_det    = bus.in_clk & ~in_clk_q;
        pending_d   = pending_q;
        pend_data_d = pend_data_q;
        smp_d       = smp_q;
        wr_ptr_d    = wr_ptr_q;
        phase_d     = phase_q;
        k_d         = k_q;
        acc_d       = acc_q;
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        consume     = 1'b0;
        // wr_ptr already points past the newest sample, so tap k reads newest-k.
        rd_idx      = wr_ptr_q - AW'(1) - k_q;
        prod        = PROD_W'(smp_q[rd_idx]) * PROD_W'(coef);

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    consume         = 1'b1;
                    smp_d[wr_ptr_q] = pend_data_q;
                    wr_ptr_d        = wr_ptr_q + AW'(1);
                    if (phase_q == PH_W'(DECIM - 1)) begin
                        phase_d = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            ST_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + AW'(1);
                if (k_q == AW'(TAPS - 1)) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                out_data_d  = OUT_W'(saturate((longint'(acc_q) + RND) >>> OUT_SHIFT, OUT_W));
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge beats a same-cycle consume; otherwise a full slot drops it.
        if (consume) begin
            pending_d = 1'b0;
        end
        if (edge_det) begin
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
            end else begin
                pending_d   = 1'b1;
                pend_data_d = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_clk_q    <= 1'b1;
            pending_q   <= 1'b0;
            pend_data_q <= '0;
            smp_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            phase_q     <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            in_clk_q    <= in_clk_d;
            pending_q   <= pending_d;
            pend_data_q <= pend_data_d;
            smp_q       <= smp_d;
            wr_ptr_q    <= wr_ptr_d;
            phase_q     <= phase_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule
